mux_n_scan: RTL and testbench

MUX_N_SCAN -- requirements
Module: mux_n_scan

---
 rtl/mux_n_scan.sv | 112 +++++++++++
 tb/tb_mux_n_scan.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux_n_scan.sv
// N-channel registered multiplexer with manual select and auto-scan mode.
// In scan mode, each channel is shown for DWELL enabled cycles before the pointer advances.
module mux_n_scan #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int DWELL = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  i,
  input  logic [SW-1:0]   s,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    o,
  output logic [SW-1:0]   ch,
  output logic            valid,
  output logic            step,
  output logic            sel_err
);

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [SW-1:0] PTR_LAST = SW'(N - 1);

  logic [W-1:0]  o_q,   o_d;
  logic [SW-1:0] ch_q,  ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          step_q,  step_d;
  logic          sel_err_q, sel_err_d;
  logic          prev_mode_q, prev_mode_d;

  // An out-of-range index matches no channel and therefore yields zero.
  function automatic logic [W-1:0] pick(input logic [N*W-1:0] data,
                                        input logic [SW-1:0]  idx);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(idx) == k) r = data[k*W +: W];
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default here so no path can leave it unassigned and infer a latch.
    o_d         = o_q;
    ch_d        = ch_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    step_d      = 1'b0;
    sel_err_d   = sel_err_q;
    prev_mode_d = prev_mode_q;

    if (en) begin
      prev_mode_d = mode;
      valid_d     = 1'b1;
      if (!mode) begin
        o_d       = pick(i, s);
        ch_d      = s;
        sel_err_d = (int'(s) >= N);
        cnt_d     = '0;
      end else begin
        sel_err_d = 1'b0;
        if (!prev_mode_q) begin
          ptr_d  = (int'(s) >= N) ? '0 : s;
          cnt_d  = '0;
          step_d = 1'b1;
        end else if (cnt_q == DWELL_LAST) begin
          ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
          cnt_d  = '0;
          step_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + 16'd1;
        end
        o_d  = pick(i, ptr_d);
        ch_d = ptr_d;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q         <= '0;
      ch_q        <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      step_q      <= 1'b0;
      sel_err_q   <= 1'b0;
      prev_mode_q <= 1'b0;
    end else begin
      o_q         <= o_d;
      ch_q        <= ch_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      step_q      <= step_d;
      sel_err_q   <= sel_err_d;
      prev_mode_q <= prev_mode_d;
    end
  end

  assign o       = o_q;
  assign ch      = ch_q;
  assign valid   = valid_q;
  assign step    = step_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_n_scan.sv
// Directed bench for mux_n_scan: four parameterisations cover manual select, range errors,
// dwell/wrap sequencing, enable pause, async reset abort and single-cycle dwell.
module tb_mux_n_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a: W=8 N=4 DWELL=4
  logic [31:0] i_a; logic [1:0] s_a; logic mode_a, en_a;
  logic [7:0]  o_a; logic [1:0] ch_a; logic valid_a, step_a, err_a;
  // b: W=8 N=4 DWELL=3
  logic [31:0] i_b; logic [1:0] s_b; logic mode_b, en_b;
  logic [7:0]  o_b; logic [1:0] ch_b; logic valid_b, step_b, err_b;
  // c: W=8 N=3 DWELL=2
  logic [23:0] i_c; logic [1:0] s_c; logic mode_c, en_c;
  logic [7:0]  o_c; logic [1:0] ch_c; logic valid_c, step_c, err_c;
  // d: W=8 N=2 DWELL=1
  logic [15:0] i_d; logic s_d; logic mode_d, en_d;
  logic [7:0]  o_d; logic ch_d; logic valid_d, step_d, err_d;

  mux_n_scan #(.W(8), .N(4), .DWELL(4)) u_a (
    .clk(clk), .rst(rst), .i(i_a), .s(s_a), .mode(mode_a), .en(en_a),
    .o(o_a), .ch(ch_a), .valid(valid_a), .step(step_a), .sel_err(err_a));
  mux_n_scan #(.W(8), .N(4), .DWELL(3)) u_b (
    .clk(clk), .rst(rst), .i(i_b), .s(s_b), .mode(mode_b), .en(en_b),
    .o(o_b), .ch(ch_b), .valid(valid_b), .step(step_b), .sel_err(err_b));
  mux_n_scan #(.W(8), .N(3), .DWELL(2)) u_c (
    .clk(clk), .rst(rst), .i(i_c), .s(s_c), .mode(mode_c), .en(en_c),
    .o(o_c), .ch(ch_c), .valid(valid_c), .step(step_c), .sel_err(err_c));
  mux_n_scan #(.W(8), .N(2), .DWELL(1)) u_d (
    .clk(clk), .rst(rst), .i(i_d), .s(s_d), .mode(mode_d), .en(en_d),
    .o(o_d), .ch(ch_d), .valid(valid_d), .step(step_d), .sel_err(err_d));

  typedef struct {
    logic [1:0] s; logic mode; logic en;
    logic [7:0] o; logic [1:0] ch; logic valid; logic step; logic err;
  } vec_t;

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed output view of instance a: {o, ch, valid, step, sel_err}.
  function automatic logic [31:0] pack_a();
    return {19'd0, o_a, ch_a, valid_a, step_a, err_a};
  endfunction

  vec_t tbl[17];
  int   exp_ch;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_a = 32'h4433_2211; s_a = '0; mode_a = 1'b0; en_a = 1'b0;
    i_b = 32'h4433_2211; s_b = '0; mode_b = 1'b0; en_b = 1'b0;
    i_c = 24'h33_2211;   s_c = '0; mode_c = 1'b0; en_c = 1'b0;
    i_d = 16'hBBAA;      s_d = '0; mode_d = 1'b0; en_d = 1'b0;

    tbl[0]  = '{2'd0, 1'b0, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{2'd1, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{2'd2, 1'b0, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{2'd3, 1'b0, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{2'd0, 1'b0, 1'b0, 8'h44, 2'd3, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{2'd1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{2'd1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{2'd1, 1'b1, 1'b0, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{2'd1, 1'b1, 1'b0, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{2'd1, 1'b1, 1'b0, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{2'd1, 1'b1, 1'b0, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{2'd1, 1'b1, 1'b0, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{2'd1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{2'd1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{2'd1, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{2'd0, 1'b0, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{2'd3, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1, 1'b1, 1'b0};

    #7;
    check("reset_a", pack_a(), 32'd0);
    check("reset_b", {19'd0, o_b, ch_b, valid_b, step_b, err_b}, 32'd0);
    check("reset_c", {19'd0, o_c, ch_c, valid_c, step_c, err_c}, 32'd0);
    check("reset_d", {20'd0, o_d, ch_d, valid_d, step_d, err_d}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // b: manual on ch2, then scan entry at s=2 with DWELL=3 and wrap 3->0.
    en_b = 1'b1; mode_b = 1'b0; s_b = 2'd2;
    tick();
    check("b_manual", {o_b, 6'd0, ch_b, valid_b, step_b}, {8'h33, 6'd0, 2'd2, 1'b1, 1'b0});
    mode_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_ch = (2 + k / 3) % 4;
      check($sformatf("b_scan%0d", k), {o_b, 6'd0, ch_b, step_b, err_b},
            {8'(8'h11 * (exp_ch + 1)), 6'd0, 2'(exp_ch), (k % 3 == 0), 1'b0});
    end
    en_b = 1'b0;

    // c: N=3, out-of-range select and scan entry clamped to channel 0.
    en_c = 1'b1; mode_c = 1'b0; s_c = 2'd3;
    tick();
    check("c_oor", {o_c, 6'd0, ch_c, valid_c, err_c}, {8'h00, 6'd0, 2'd3, 1'b1, 1'b1});
    s_c = 2'd1;
    tick();
    check("c_inrange", {o_c, 6'd0, ch_c, valid_c, err_c}, {8'h22, 6'd0, 2'd1, 1'b1, 1'b0});
    mode_c = 1'b1; s_c = 2'd3;
    tick();
    check("c_entry_clamp", {o_c, 6'd0, ch_c, step_c, err_c}, {8'h11, 6'd0, 2'd0, 1'b1, 1'b0});
    tick();
    check("c_dwell", {o_c, 6'd0, ch_c, step_c, err_c}, {8'h11, 6'd0, 2'd0, 1'b0, 1'b0});
    tick();
    check("c_adv", {o_c, 6'd0, ch_c, step_c, err_c}, {8'h22, 6'd0, 2'd1, 1'b1, 1'b0});
    en_c = 1'b0;

    // d: N=2, DWELL=1 toggles every cycle and tracks live input.
    en_d = 1'b1; mode_d = 1'b1; s_d = 1'b0;
    tick();
    check("d_entry", {o_d, 6'd0, ch_d, step_d}, {8'hAA, 6'd0, 1'b0, 1'b1});
    i_d = 16'hCCAA;
    tick();
    check("d_t1", {o_d, 6'd0, ch_d, step_d}, {8'hCC, 6'd0, 1'b1, 1'b1});
    tick();
    check("d_t2", {o_d, 6'd0, ch_d, step_d}, {8'hAA, 6'd0, 1'b0, 1'b1});
    i_d = 16'hCCDD;
    tick();
    check("d_t3", {o_d, 6'd0, ch_d, step_d}, {8'hCC, 6'd0, 1'b1, 1'b1});
    tick();
    check("d_t4", {o_d, 6'd0, ch_d, step_d}, {8'hDD, 6'd0, 1'b0, 1'b1});
    en_d = 1'b0;

    // a: held disabled since reset, so still at reset values.
    check("a_idle", pack_a(), 32'd0);
    for (int k = 0; k < 17; k++) begin
      s_a = tbl[k].s; mode_a = tbl[k].mode; en_a = tbl[k].en;
      tick();
      check($sformatf("a_vec%0d", k), pack_a(),
            {19'd0, tbl[k].o, tbl[k].ch, tbl[k].valid, tbl[k].step, tbl[k].err});
    end
    tick();
    check("a_steady", pack_a(), {19'd0, 8'h44, 2'd3, 1'b1, 1'b0, 1'b0});

    // Async reset between edges mid-scan.
    #3;
    rst = 1'b1;
    #1;
    check("a_async_rst", pack_a(), 32'd0);
    tick();
    check("a_rst_held", pack_a(), 32'd0);
    #2;
    rst = 1'b0; en_a = 1'b0; s_a = 2'd1; mode_a = 1'b1;
    tick();
    check("a_post_rst_disabled", pack_a(), 32'd0);
    en_a = 1'b1;
    tick();
    check("a_post_rst_entry", pack_a(), {19'd0, 8'h22, 2'd1, 1'b1, 1'b1, 1'b0});
    tick();
    check("a_post_rst_dwell", pack_a(), {19'd0, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
